// File: rtl/regfile_write_port.sv
// regfile_write_port: write side of the 16x16 register file.
// Buffers valid/ready write requests in a FIFO and retires one per cycle.
//
// Ports:
//   clk, reset       clock, async active-high reset
//   wr_valid/ready   request handshake
//   wr_addr/data/be  write target, data, byte enables
//   commit_en        allow queue head to retire
//   flush            drop all pending writes
//   regs             flat register bus, R0 at [15:0]
//   pending          queued write count
//   commit_valid     pulse: a write retired last edge
//   commit_addr      address of that write
module regfile_write_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [1:0]                     wr_be,
  input  logic                           commit_en,
  input  logic                           flush,
  output logic [DATA_W*(2**ADDR_W)-1:0]  regs,
  output logic [2:0]                     pending,
  output logic                           commit_valid,
  output logic [ADDR_W-1:0]              commit_addr
);

  localparam int NR = 2**ADDR_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [1:0]        q_be   [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2:0]        count;
  logic [DATA_W-1:0] rf [NR];
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] merged;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on registered count and flush.
  assign wr_ready = !flush && (count != 3'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != 3'd0) && commit_en && !flush;
  assign pending  = count;
  assign h_addr   = q_addr[head];

  // Byte merge against the register's value at retire time.
  always_comb begin
    merged = rf[h_addr];
    if (q_be[head][0])
      merged[7:0] = q_data[head][7:0];
    if (q_be[head][1])
      merged[DATA_W-1:8] = q_data[head][DATA_W-1:8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_be[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_addr[tail] <= wr_addr;
        q_data[tail] <= wr_data;
        q_be[tail]   <= wr_be;
        tail         <= nxt(tail);
      end
      if (pop)
        head <= nxt(head);
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      for (int i = 0; i < NR; i++)
        rf[i] <= '0;
    end else begin
      commit_valid <= pop;
      if (pop) begin
        rf[h_addr]  <= merged;
        commit_addr <= h_addr;
      end
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = rf[g];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port: scoreboard bench for regfile_write_port.
// Queue-level reference model; monitor checks outputs at negedge.
module tb_regfile_write_port;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [3:0]   wr_addr = '0;
  logic [15:0]  wr_data = '0;
  logic [1:0]   wr_be = '0;
  logic         commit_en = 1'b0;
  logic         flush = 1'b0;
  logic [255:0] regs;
  logic [2:0]   pending;
  logic         commit_valid;
  logic [3:0]   commit_addr;

  regfile_write_port #(
    .DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .commit_en(commit_en),
    .flush(flush), .regs(regs),
    .pending(pending),
    .commit_valid(commit_valid),
    .commit_addr(commit_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] v;
  } cm_t;

  int tests = 0;
  int fails = 0;

  logic [15:0] mregs [16];
  wr_t         mq [$];
  cm_t         expq [$];
  logic [2:0]   e_pend = '0;
  logic         e_ready = 1'b1;
  logic [255:0] e_flat = '0;
  bit           chk_en = 1'b0;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] flat_model();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[i*16 +: 16] = mregs[i];
    return f;
  endfunction

  // One cycle of stimulus; model predicts the coming edge.
  task automatic step(input bit v, input logic [3:0] a,
                      input logic [15:0] d, input logic [1:0] be,
                      input bit ce, input bit fl);
    wr_t h;
    bit  ret;
    bit  acc;
    @(posedge clk);
    #2;
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    wr_be     = be;
    commit_en = ce;
    flush     = fl;
    e_pend  = 3'(mq.size());
    e_ready = !fl && (mq.size() != DEPTH);
    e_flat  = flat_model();
    if (fl) begin
      mq.delete();
    end else begin
      ret = (mq.size() > 0) && ce;
      acc = v && (mq.size() != DEPTH);
      if (ret) begin
        h = mq.pop_front();
        if (h.be[0]) mregs[h.a][7:0]  = h.d[7:0];
        if (h.be[1]) mregs[h.a][15:8] = h.d[15:8];
        expq.push_back('{a: h.a, v: mregs[h.a]});
      end
      if (acc) mq.push_back('{a: a, d: d, be: be});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
  endtask

  // Reset asserted between edges; effects must be immediate.
  task automatic do_reset();
    @(posedge clk);
    #2;
    wr_valid = 0;
    commit_en = 0;
    flush = 0;
    reset = 1'b1;
    #1;
    chk("rst_regs", regs, '0);
    chk("rst_pending", pending, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_addr", commit_addr, 0);
    mq.delete();
    expq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    e_pend = '0;
    e_ready = 1'b1;
    e_flat = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    cm_t c;
    if (chk_en && !reset) begin
      chk("pending", pending, e_pend);
      chk("wr_ready", wr_ready, e_ready);
      chk("regs", regs, e_flat);
      if (commit_valid) begin
        if (expq.size() == 0) begin
          chk("commit_spurious", 1, 0);
        end else begin
          c = expq.pop_front();
          chk("commit_addr", commit_addr, c.a);
          chk("commit_value", regs[c.a*16 +: 16], c.v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    repeat (2) @(posedge clk);
    do_reset();
    chk_en = 1'b1;

    step(1, 3, 16'hBEEF, 2'b11, 1, 0);
    idle(3);
    chk("r3_beef", regs[63:48], 16'hBEEF);

    step(1, 1, 16'h0001, 2'b11, 0, 0);
    step(1, 2, 16'h0002, 2'b11, 0, 0);
    step(1, 4, 16'h0004, 2'b11, 0, 0);
    step(1, 4, 16'h0004, 2'b11, 1, 0);
    step(1, 4, 16'h0004, 2'b11, 1, 0);
    idle(3);
    chk("r4_four", regs[79:64], 16'h0004);

    step(1, 5, 16'h1234, 2'b11, 1, 0);
    step(1, 5, 16'hABCD, 2'b01, 1, 0);
    step(1, 5, 16'hFF00, 2'b10, 1, 0);
    step(1, 5, 16'h5555, 2'b00, 1, 0);
    idle(3);
    chk("r5_merge", regs[95:80], 16'hFFCD);

    step(1, 7, 16'h0001, 2'b11, 1, 0);
    step(1, 7, 16'h0002, 2'b11, 1, 0);
    idle(3);
    chk("r7_last", regs[127:112], 16'h0002);

    step(1, 8, 16'h1111, 2'b11, 0, 0);
    step(1, 9, 16'h2222, 2'b11, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    idle(3);
    chk("r8_flushed", regs[143:128], 16'h0000);

    step(1, 1, 16'h00FF, 2'b11, 1, 0);
    idle(2);
    step(1, 10, 16'hAAAA, 2'b11, 0, 0);
    step(1, 11, 16'hBBBB, 2'b11, 0, 0);
    do_reset();
    step(1, 2, 16'hC0DE, 2'b11, 1, 0);
    idle(3);
    chk("r2_after_rst", regs[47:32], 16'hC0DE);

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7,
             4'($urandom_range(0, 15)),
             16'($urandom()),
             2'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 19) == 0);
      end
    end
    idle(6);
    chk("commit_missing", 32'(expq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
